// File: rtl/dna_rd_pkg.sv
// Shared types and constants for the DNA FIFO read controller.
package dna_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dna_rd_state_t;

  localparam int DNA_RD_MAX_DEPTH = 128;
  localparam int DNA_RD_BUF_DEPTH = 2;

  // FIFO depth from the runtime address width; widths beyond 7 clamp to the max.
  function automatic logic [7:0] dna_rd_depth(input logic [6:0] aw);
    if (aw >= 7'd7) return 8'(DNA_RD_MAX_DEPTH);
    return 8'd1 << aw;
  endfunction

endpackage

// File: rtl/dna_rd_skid_buf.sv
// Two-entry data+last skid buffer; entry 0 is always the head.
module dna_rd_skid_buf
  import dna_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  valid,
  output logic [1:0]            count
);

  logic [DATA_WIDTH:0] ent0, ent1;
  logic                pop_ok, push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count < 2'(DNA_RD_BUF_DEPTH)) || pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) ent0 <= {push_last, push_data};
          else               ent1 <= {push_last, push_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
          if (count == 2'd1) ent0 <= {push_last, push_data};
          else begin
            ent0 <= ent1;
            ent1 <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = ent0[DATA_WIDTH-1:0];
  assign out_last = ent0[DATA_WIDTH];
  assign valid    = (count != 2'd0);

endmodule

// File: rtl/dna_fifo_reader.sv
// Burst read controller for the DNA sample FIFO with a valid/ready/last output stream.
// Define DNA_RD_OCC_CHK_EN to enable occupancy tracking, read gating and overflow flagging.
module dna_fifo_reader
  import dna_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            addr_width,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  wr_seen,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [7:0]            occupancy,
  output logic                  err_overflow
);

  dna_rd_state_t        state;
  logic [LEN_WIDTH-1:0] rem;
  logic [1:0]           buf_cnt;
  logic                 pop, occ_ok;

  assign pop     = m_valid && m_ready;
  assign fifo_rd = (state == RUN) && (rem != '0) &&
                   (buf_cnt < 2'(DNA_RD_BUF_DEPTH)) && occ_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (burst_len != '0) begin
            state <= RUN;
            rem   <= burst_len;
            busy  <= 1'b1;
          end else begin
            done <= 1'b1;
          end
        end
        RUN: if (fifo_rd) begin
          rem <= rem - LEN_WIDTH'(1);
          if (rem == LEN_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN: if (pop && m_last) begin
          // The flagged word is always the final buffered one, so its handshake ends the burst.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dna_rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_rd),
    .push_data(fifo_r_data),
    .push_last(rem == LEN_WIDTH'(1)),
    .pop      (pop),
    .out_data (m_data),
    .out_last (m_last),
    .valid    (m_valid),
    .count    (buf_cnt)
  );

`ifdef DNA_RD_OCC_CHK_EN
  logic [7:0] occ_q, depth;
  logic       err_q, full;

  assign depth = dna_rd_depth(addr_width);
  assign full  = (occ_q >= depth);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (wr_seen && full) err_q <= 1'b1;
      if (wr_seen && fifo_rd) occ_q <= occ_q;
      else if (wr_seen && !full) occ_q <= occ_q + 8'd1;
      else if (fifo_rd) occ_q <= occ_q - 8'd1;
    end
  end

  assign occ_ok       = (occ_q != 8'd0);
  assign occupancy    = occ_q;
  assign err_overflow = err_q;
`else
  logic unused_ok;
  assign unused_ok    = ^{addr_width, wr_seen};
  assign occ_ok       = 1'b1;
  assign occupancy    = 8'd0;
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dna_fifo_reader.sv
// Directed bench for dna_fifo_reader with a behavioural FIFO register file on the read pins.
module tb_dna_fifo_reader;

`ifdef DNA_RD_OCC_CHK_EN
  localparam bit OCC_EN = 1'b1;
`else
  localparam bit OCC_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic [6:0]  addr_width = 7'd7;
  logic        start = 1'b0, wr_seen = 1'b0, m_ready = 1'b0;
  logic [15:0] burst_len = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, fifo_rd, m_valid, m_last, err_overflow;
  logic [7:0]  fifo_r_data, m_data, occupancy;

  int checks = 0, errs = 0;

  always #5 clk = ~clk;

  dna_fifo_reader #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .addr_width(addr_width), .start(start),
    .burst_len(burst_len), .busy(busy), .done(done), .wr_seen(wr_seen),
    .fifo_rd(fifo_rd), .fifo_r_data(fifo_r_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .occupancy(occupancy), .err_overflow(err_overflow)
  );

  // FIFO register file: write on wr_seen, read pointer advances on fifo_rd.
  logic [7:0] mem [128];
  logic [6:0] wptr, rptr, mask;
  assign mask        = 7'((8'd1 << addr_width) - 8'd1);
  assign fifo_r_data = mem[rptr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else begin
      if (wr_seen) begin
        mem[wptr] <= wdata;
        wptr      <= (wptr + 7'd1) & mask;
      end
      if (fifo_rd) rptr <= (rptr + 7'd1) & mask;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic wr; logic [7:0] wd; logic st; logic [15:0] len; logic rdy;
    logic busy, rd, mv; logic [7:0] data; logic last, done; logic [7:0] occ;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [7:0] wd, logic st, logic [15:0] len, logic rdy,
                              logic b, logic rd, logic mv, logic [7:0] d, logic l, logic dn,
                              logic [7:0] occ);
    vec_t v;
    v.wr = wr; v.wd = wd; v.st = st; v.len = len; v.rdy = rdy;
    v.busy = b; v.rd = rd; v.mv = mv; v.data = d; v.last = l; v.done = dn; v.occ = occ;
    return v;
  endfunction

  vec_t tv [14];
  logic [7:0] got_d [$];
  logic       got_l [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    bit seen_done;

    // 4-word burst, then a zero-length request.
    tv[0]  = mk(1, 8'h1B, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    tv[1]  = mk(1, 8'h2C, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 1);
    tv[2]  = mk(1, 8'h3D, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 2);
    tv[3]  = mk(1, 8'h4E, 0, 0, 0,  0, 0, 0, 8'h00, 0, 0, 3);
    tv[4]  = mk(0, 8'h00, 1, 4, 1,  0, 0, 0, 8'h00, 0, 0, 4);
    tv[5]  = mk(0, 8'h00, 0, 0, 1,  1, 1, 0, 8'h00, 0, 0, 4);
    tv[6]  = mk(0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h1B, 0, 0, 3);
    tv[7]  = mk(0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h2C, 0, 0, 2);
    tv[8]  = mk(0, 8'h00, 0, 0, 1,  1, 1, 1, 8'h3D, 0, 0, 1);
    tv[9]  = mk(0, 8'h00, 0, 0, 1,  1, 0, 1, 8'h4E, 1, 0, 0);
    tv[10] = mk(0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h00, 0, 1, 0);
    tv[11] = mk(0, 8'h00, 1, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    tv[12] = mk(0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h00, 0, 1, 0);
    tv[13] = mk(0, 8'h00, 0, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);

    #3;
    chk("rst busy", busy, 0);       chk("rst done", done, 0);
    chk("rst fifo_rd", fifo_rd, 0); chk("rst m_valid", m_valid, 0);
    chk("rst m_last", m_last, 0);   chk("rst m_data", m_data, 0);
    chk("rst occ", occupancy, 0);   chk("rst err", err_overflow, 0);
    step(); step();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      wr_seen = tv[i].wr; wdata = tv[i].wd; start = tv[i].st;
      burst_len = tv[i].len; m_ready = tv[i].rdy;
      chk($sformatf("v%0d busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d fifo_rd", i), fifo_rd, tv[i].rd);
      chk($sformatf("v%0d m_valid", i), m_valid, tv[i].mv);
      chk($sformatf("v%0d done", i), done, tv[i].done);
      chk($sformatf("v%0d occ", i), occupancy, OCC_EN ? tv[i].occ : 8'd0);
      if (tv[i].mv) begin
        chk($sformatf("v%0d m_data", i), m_data, tv[i].data);
        chk($sformatf("v%0d m_last", i), m_last, tv[i].last);
      end
      step();
    end
    start = 0;

    // Backpressure: 3-word burst with m_ready low for 5 cycles.
    wr_seen = 1; wdata = 8'h11; step();
    wdata = 8'h22; step();
    wdata = 8'h33; step();
    wr_seen = 0; m_ready = 0; start = 1; burst_len = 3;
    step();
    start = 0; rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin start = 1; burst_len = 5; end
      else start = 0;
      if (fifo_rd) rd_cnt++;
      if (m_valid) chk($sformatf("bp hold%0d m_data", k), m_data, 8'h11);
      step();
    end
    start = 0;
    chk("bp rd pulses", rd_cnt, 2);
    chk("bp m_valid", m_valid, 1);
    m_ready = 1; seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin seen_done = 1; break; end
      if (fifo_rd) rd_cnt++;
      if (m_valid) begin got_d.push_back(m_data); got_l.push_back(m_last); end
      step();
    end
    chk("bp done", seen_done, 1);
    chk("bp total rd", rd_cnt, 3);
    chk("bp words", got_d.size(), 3);
    if (got_d.size() == 3) begin
      chk("bp w0", {got_l[0], got_d[0]}, 9'h011);
      chk("bp w1", {got_l[1], got_d[1]}, 9'h022);
      chk("bp w2", {got_l[2], got_d[2]}, 9'h133);
    end
    step();
    chk("bp dropped start busy", busy, 0);
    chk("bp dropped start rd", fifo_rd, 0);

`ifdef DNA_RD_OCC_CHK_EN
    // Underrun: reads wait for each write.
    start = 1; burst_len = 2; step();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ur stall%0d rd", k), fifo_rd, 0);
      chk($sformatf("ur stall%0d busy", k), busy, 1);
      step();
    end
    wr_seen = 1; wdata = 8'h55; step();
    wr_seen = 0;
    chk("ur rd1", fifo_rd, 1); step();
    chk("ur gap rd", fifo_rd, 0);
    chk("ur w0", {m_valid, m_last, m_data}, {2'b10, 8'h55}); step();
    chk("ur gap2 rd", fifo_rd, 0);
    wr_seen = 1; wdata = 8'hAA; step();
    wr_seen = 0;
    chk("ur rd2", fifo_rd, 1); step();
    chk("ur w1", {m_valid, m_last, m_data}, {2'b11, 8'hAA});
    chk("ur after rd", fifo_rd, 0); step();
    chk("ur done", done, 1);
    chk("ur busy", busy, 0);
`else
    // Without occupancy gating an unwritten slot is read straight away as 0.
    start = 1; burst_len = 1; step();
    start = 0;
    chk("nogate rd", fifo_rd, 1); step();
    chk("nogate w0", {m_valid, m_last, m_data}, {2'b11, 8'h00}); step();
    chk("nogate done", done, 1);
`endif
    step();

    // Overflow on a 4-deep FIFO.
    addr_width = 7'd2; wr_seen = 1; wdata = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("ov occ%0d", k), occupancy, OCC_EN ? 8'((k < 4) ? k + 1 : 4) : 8'd0);
      chk($sformatf("ov err%0d", k), err_overflow, (OCC_EN && k == 4) ? 1'b1 : 1'b0);
    end
    wr_seen = 0;
    step(); step();
    chk("ov err sticky", err_overflow, OCC_EN);
    reset = 1; #1;
    chk("ov rst err", err_overflow, 0);
    chk("ov rst occ", occupancy, 0);
    #1 reset = 0; addr_width = 7'd7;
    step();

    // Reset in RUN with one word buffered.
    wr_seen = 1; wdata = 8'h66; step();
    wdata = 8'h77; step();
    wr_seen = 0; m_ready = 0; start = 1; burst_len = 2; step();
    start = 0;
    chk("mr rd", fifo_rd, 1); step();
    chk("mr buffered", {m_valid, m_data}, {1'b1, 8'h66});
    reset = 1; #1;
    chk("mr busy", busy, 0);       chk("mr done", done, 0);
    chk("mr fifo_rd", fifo_rd, 0); chk("mr m_valid", m_valid, 0);
    chk("mr m_last", m_last, 0);   chk("mr m_data", m_data, 0);
    chk("mr occ", occupancy, 0);   chk("mr err", err_overflow, 0);
    #1 reset = 0; m_ready = 1;
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done || m_valid || busy) seen_done = 1;
    end
    chk("mr quiet after reset", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
